// File: rtl/prog_instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module   : prog_instruction_memory
//  Purpose  : Word-organised program memory. After reset it zero-fills
//             (optional), then accepts a stream of loader words, then serves
//             one-cycle-latency instruction fetches.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_instruction_memory #(
  parameter int WORD_LEN       = 32,
  parameter int DEPTH_BYTES    = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              load_valid_i,
  input  logic [WORD_LEN-1:0]                               load_data_i,
  input  logic                                              load_last_i,
  output logic                                              load_ready_o,
  input  logic                                              fetch_req_i,
  input  logic [WORD_LEN-1:0]                               fetch_addr_i,
  output logic                                              fetch_valid_o,
  output logic [WORD_LEN-1:0]                               instruction_o,
  output logic                                              fetch_fault_o,
  output logic                                              busy_o,
  output logic [$clog2(DEPTH_BYTES/(WORD_LEN/8)):0]         load_count_o
);

  localparam int BYTES_PER_WORD = WORD_LEN / 8;
  localparam int DEPTH_WORDS    = DEPTH_BYTES / BYTES_PER_WORD;
  localparam int AW             = $clog2(DEPTH_WORDS);
  localparam int OFF            = $clog2(BYTES_PER_WORD);
  // Range check is done wider than the address so DEPTH_BYTES never aliases.
  localparam int XW             = WORD_LEN + 33;

  localparam logic [WORD_LEN-1:0] ALIGN_MASK    = WORD_LEN'(BYTES_PER_WORD - 1);
  localparam logic [AW:0]         LAST_IDX      = (AW + 1)'(DEPTH_WORDS - 1);
  localparam logic [AW-1:0]       CLR_LAST      = AW'(DEPTH_WORDS - 1);
  localparam logic [XW-1:0]       DEPTH_BYTES_X = XW'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e                state_q;
  logic [AW-1:0]         clr_ptr_q;
  logic [AW:0]           load_count_q;
  logic                  load_ready_q;
  logic                  fetch_valid_q;
  logic [WORD_LEN-1:0]   instruction_q;
  logic                  fetch_fault_q;
  logic [WORD_LEN-1:0]   mem_q [DEPTH_WORDS];

  logic                  w_accept;
  logic                  w_load_done;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic [AW-1:0]         w_fetch_idx;
  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [WORD_LEN-1:0]   w_wdata;

  assign w_accept       = (state_q == S_LOAD) && load_valid_i && load_ready_q;
  assign w_load_done    = load_last_i || (load_count_q == LAST_IDX);
  assign w_misaligned   = (fetch_addr_i & ALIGN_MASK) != '0;
  assign w_out_of_range = XW'(fetch_addr_i) >= DEPTH_BYTES_X;
  assign w_fetch_idx    = fetch_addr_i[OFF +: AW];

  // Single memory write port shared by the clear sweep and the loader; reset blocks writes.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!reset_i) begin
      if (state_q == S_CLEAR) begin
        w_we    = 1'b1;
        w_waddr = clr_ptr_q;
      end else if (w_accept) begin
        w_we    = 1'b1;
        w_waddr = load_count_q[AW-1:0];
        w_wdata = load_data_i;
      end
    end
  end

  // Memory array: no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      mem_q[w_waddr] <= w_wdata;
    end
  end

  // Control FSM plus registered fetch result.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_LOAD;
      clr_ptr_q     <= '0;
      load_count_q  <= '0;
      load_ready_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      instruction_q <= '0;
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      instruction_q <= '0;
      fetch_fault_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == CLR_LAST) begin
            state_q      <= S_LOAD;
            load_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            load_count_q <= load_count_q + 1'b1;
            if (w_load_done) begin
              state_q      <= S_RUN;
              load_ready_q <= 1'b0;
            end
          end else begin
            // Covers entry straight from reset when the clear sweep is skipped.
            load_ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (fetch_req_i) begin
            fetch_valid_q <= 1'b1;
            if (w_misaligned || w_out_of_range) begin
              fetch_fault_q <= 1'b1;
            end else begin
              instruction_q <= mem_q[w_fetch_idx];
            end
          end
        end
        default: begin
          state_q      <= S_CLEAR;
          clr_ptr_q    <= '0;
          load_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready_o  = load_ready_q;
  assign fetch_valid_o = fetch_valid_q;
  assign instruction_o = instruction_q;
  assign fetch_fault_o = fetch_fault_q;
  assign busy_o        = (state_q != S_RUN);
  assign load_count_o  = load_count_q;

endmodule
`default_nettype wire

// File: doc/prog_instruction_memory.md
PROG_INSTRUCTION_MEMORY -- requirements
Module: prog_instruction_memory

Interface
REQ-001 Parameter WORD_LEN, default 32, instruction/load word width in bits.
REQ-002 Parameter DEPTH_BYTES, default 1024, byte-addressed capacity; DEPTH_WORDS = DEPTH_BYTES/(WORD_LEN/8), power of two.
REQ-003 Parameter CLEAR_ON_RESET, default 1, 1 = zero-fill all words after reset, 0 = skip clear.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 LOAD_VALID  input  1  loader word valid.
REQ-007 LOAD_DATA  input  WORD_LEN  loader word, written as one whole instruction.
REQ-008 LOAD_LAST  input  1  marks final loader word; qualified by LOAD_VALID.
REQ-009 LOAD_READY  output  1  block accepts a loader word this cycle.
REQ-010 FETCH_REQ  input  1  fetch request.
REQ-011 FETCH_ADDR  input  WORD_LEN  byte address of instruction.
REQ-012 FETCH_VALID  output  1  INSTRUCTION/FETCH_FAULT valid this cycle.
REQ-013 INSTRUCTION  output  WORD_LEN  fetched instruction.
REQ-014 FETCH_FAULT  output  1  fetch was misaligned or out of range.
REQ-015 BUSY  output  1  high in every state except RUN.
REQ-016 LOAD_COUNT  output  clog2(DEPTH_WORDS)+1  words accepted since last reset.

Function
REQ-017 States: CLEAR, LOAD, RUN; one-hot or encoded, no other reachable state.
REQ-018 CLEAR: writes 0 to word index clr_ptr each cycle, clr_ptr 0..DEPTH_WORDS-1; after writing index DEPTH_WORDS-1 the next state is LOAD (exactly DEPTH_WORDS cycles in CLEAR).
REQ-019 LOAD: LOAD_READY=1; on LOAD_VALID&&LOAD_READY, LOAD_DATA written to word index LOAD_COUNT, LOAD_COUNT increments.
REQ-020 LOAD -> RUN on an accepted word with LOAD_LAST=1, or on acceptance of word index DEPTH_WORDS-1 (full); LOAD_READY=0 from the next cycle.
REQ-021 LOAD_VALID while LOAD_READY=0 is ignored; no write, no count change.
REQ-022 RUN: FETCH_REQ at cycle N produces FETCH_VALID=1 at cycle N+1 with result; back-to-back requests give one result per cycle; FETCH_REQ=0 gives FETCH_VALID=0 next cycle.
REQ-023 Word index = FETCH_ADDR >> log2(WORD_LEN/8); word returned exactly as loaded.
REQ-024 FETCH_ADDR low log2(WORD_LEN/8) bits nonzero -> FETCH_FAULT=1, INSTRUCTION=0.
REQ-025 FETCH_ADDR >= DEPTH_BYTES (full-width compare, no wrap) -> FETCH_FAULT=1, INSTRUCTION=0.
REQ-026 Valid fetch of an unloaded word returns 0 when CLEAR_ON_RESET=1; value unspecified when 0.
REQ-027 FETCH_REQ outside RUN is dropped: FETCH_VALID=0 next cycle, no queuing.
REQ-028 FETCH_VALID=0 implies INSTRUCTION=0 and FETCH_FAULT=0.
REQ-029 Memory contents are retained in RUN; no write path exists in RUN.

Reset
REQ-030 RESET=1 at an edge: state <= CLEAR (or LOAD if CLEAR_ON_RESET=0), clr_ptr=0, LOAD_COUNT=0, LOAD_READY=0, FETCH_VALID=0, INSTRUCTION=0, FETCH_FAULT=0, BUSY=1.
REQ-031 RESET overrides all inputs in the same cycle, including mid-CLEAR, mid-LOAD, and a pending fetch (its result is discarded).
REQ-032 LOAD_READY first asserts the cycle after CLEAR completes (DEPTH_WORDS+1 cycles after RESET deasserts, CLEAR_ON_RESET=1).

Verification
REQ-033 Reset, wait for LOAD_READY; load 0x8020000A, then 0x04400800 with LOAD_LAST -> LOAD_COUNT=2, BUSY=0; fetch addr 0 then 4 back-to-back -> INSTRUCTION 0x8020000A, 0x04400800 on consecutive cycles, FETCH_FAULT=0.
REQ-034 After REQ-033 load, fetch addr 8 -> 0x00000000, no fault; fetch addr 2 -> FETCH_FAULT=1, INSTRUCTION=0; fetch addr 1024 -> FETCH_FAULT=1.
REQ-035 Load 256 words (value = index) without LOAD_LAST -> RUN after word 255, LOAD_READY=0; extra LOAD_VALID ignored, LOAD_COUNT=256; fetch 1020 -> 0x000000FF.
REQ-036 FETCH_REQ held high during CLEAR and LOAD -> FETCH_VALID stays 0; LOAD_VALID held high during CLEAR -> no word accepted before LOAD_READY.
REQ-037 RESET asserted at word 1 of a load and again while a RUN fetch is pending -> outputs per REQ-030 next cycle, no FETCH_VALID for the discarded fetch, and a fetch of addr 0 after reload returns the newly loaded word.
